// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller: size encodings,
// FSM state type and the default memory size.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int MEM_BYTES_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational; sizes other than byte/half are handled as a full word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane and extend it to a full load result
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = rd_word;
        case (offset)
            2'b00:   byte_s = rd_word[31:24];
            2'b01:   byte_s = rd_word[23:16];
            2'b10:   byte_s = rd_word[15:8];
            default: byte_s = rd_word[7:0];
        endcase
        if (offset[1]) begin
            half_s = rd_word[15:0];
        end else begin
            half_s = rd_word[31:16];
        end
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: load_data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default: load_data = rd_word;
        endcase
    end

    // Insert right-justified store data into the lanes of the word just read
    always_comb begin
        merged_word = wr_data;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'b00:   merged_word = {wr_data[7:0], rd_word[23:0]};
                    2'b01:   merged_word = {rd_word[31:24], wr_data[7:0], rd_word[15:0]};
                    2'b10:   merged_word = {rd_word[31:16], wr_data[7:0], rd_word[7:0]};
                    default: merged_word = {rd_word[31:8], wr_data[7:0]};
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    merged_word = {rd_word[31:16], wr_data[15:0]};
                end else begin
                    merged_word = {wr_data[15:0], rd_word[15:0]};
                end
            end
            default: merged_word = wr_data;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the big-endian data memory of the multi-cycle core.
// Optional build macro MISALIGN_TRAP_EN turns misaligned or reserved-size requests into error responses.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_RD,
    output logic              mem_WR,
    output logic [31:0]       mem_DAddr,
    output logic [31:0]       mem_DataIn,
    input  logic [31:0]       mem_DataOut
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - 4);

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [1:0]        eff_size_s;
    logic              range_err_s;
    logic              align_err_s;
    logic              acc_err_s;

    logic              we_r;
    logic              unsigned_r;
    logic [1:0]        size_r;
    logic [1:0]        offset_r;
    logic [31:0]       wdata_r;

    logic              ready_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [31:0]       resp_rdata_r;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic [31:0]       mem_daddr_r;
    logic [31:0]       mem_data_in_r;

    logic [31:0]       load_data_s;
    logic [31:0]       merged_word_s;

    assign accept_s   = req_valid && ready_r;
    assign req_ready  = ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_RD     = mem_rd_r;
    assign mem_WR     = mem_wr_r;
    assign mem_DAddr  = mem_daddr_r;
    assign mem_DataIn = mem_data_in_r;

    // Classify the incoming request: effective size and fault detection
    always_comb begin
        word_addr_s = {req_addr[ADDR_W-1:2], 2'b00};
        range_err_s = (word_addr_s > ADDR_LIMIT);
`ifdef MISALIGN_TRAP_EN
        eff_size_s  = req_size;
        align_err_s = (req_size == SZ_RSVD)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        eff_size_s  = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
        align_err_s = 1'b0;
`endif
        acc_err_s   = range_err_s || align_err_s;
    end

    mem_lane_align u_align (
        .size        (size_r),
        .offset      (offset_r),
        .is_unsigned (unsigned_r),
        .rd_word     (mem_DataOut),
        .wr_data     (wdata_r),
        .load_data   (load_data_s),
        .merged_word (merged_word_s)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; faulted requests skip the memory entirely
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (acc_err_s) begin
                        next_state_s = ST_RESP;
                    end else if (req_we && (eff_size_s == SZ_WORD)) begin
                        next_state_s = ST_WRITE;
                    end else begin
                        next_state_s = ST_READ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (we_r) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            ST_WRITE: next_state_s = ST_RESP;
            ST_RESP:  next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Registered strobes, request latch and read-data capture
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ready_r       <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_err_r    <= 1'b0;
            resp_rdata_r  <= 32'h0000_0000;
            mem_rd_r      <= 1'b0;
            mem_wr_r      <= 1'b0;
            mem_daddr_r   <= 32'h0000_0000;
            mem_data_in_r <= 32'h0000_0000;
            we_r          <= 1'b0;
            unsigned_r    <= 1'b0;
            size_r        <= SZ_BYTE;
            offset_r      <= 2'b00;
            wdata_r       <= 32'h0000_0000;
        end else begin
            ready_r      <= (next_state_s == ST_IDLE);
            mem_rd_r     <= (next_state_s == ST_READ);
            mem_wr_r     <= (next_state_s == ST_WRITE);
            resp_valid_r <= (next_state_s == ST_RESP);
            if (accept_s) begin
                we_r       <= req_we;
                unsigned_r <= req_unsigned;
                size_r     <= eff_size_s;
                offset_r   <= req_addr[1:0];
                wdata_r    <= req_wdata;
                resp_err_r <= acc_err_s;
                if (!acc_err_s) begin
                    mem_daddr_r <= 32'(word_addr_s);
                    if (req_we && (eff_size_s == SZ_WORD)) begin
                        mem_data_in_r <= req_wdata;
                    end
                end
            end else if (state_r == ST_READ) begin
                if (we_r) begin
                    mem_data_in_r <= merged_word_s;
                end else begin
                    resp_rdata_r <= load_data_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard testbench for mem_access_ctrl with a small behavioural data memory.
module tb_mem_access_ctrl;
    import mem_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  lat;
        logic [7:0]  rd_cyc;
        logic [7:0]  wr_cyc;
        logic [31:0] wr_word;
    } rsp_t;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_RD;
    logic        mem_WR;
    logic [31:0] mem_DAddr;
    logic [31:0] mem_DataIn;
    logic [31:0] mem_DataOut;

    logic [31:0] mem [0:7] = '{default: 32'h0000_0000};

    rsp_t        got_q[$];
    rsp_t        exp_q[$];
    int          cyc_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap_cnt = 0;
    logic [31:0] wr_word = 32'h0;
    logic [31:0] hold = 32'h0;
    time         acc_time = 0;
    int          n_pass = 0;
    int          n_total = 0;

    mem_access_ctrl #(.ADDR_W(32), .MEM_BYTES(32)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_RD(mem_RD), .mem_WR(mem_WR),
        .mem_DAddr(mem_DAddr), .mem_DataIn(mem_DataIn), .mem_DataOut(mem_DataOut)
    );

    always #5 CLK = ~CLK;

    assign mem_DataOut = mem_RD ? mem[mem_DAddr[4:2]] : 32'hDEAD_BEEF;

    always @(posedge CLK) begin
        if (mem_WR) mem[mem_DAddr[4:2]] <= mem_DataIn;
    end

    // Monitor: per-transaction latency and memory-strobe counts, pushed on resp_valid
    always @(negedge CLK) begin
        if (!RST_n || (req_valid && req_ready)) begin
            cyc_cnt <= 0;
            rd_cnt  <= 0;
            wr_cnt  <= 0;
            wr_word <= 32'h0;
        end else begin
            cyc_cnt <= cyc_cnt + 1;
            if (mem_RD) rd_cnt <= rd_cnt + 1;
            if (mem_WR) begin
                wr_cnt  <= wr_cnt + 1;
                wr_word <= mem_DataIn;
            end
            if (mem_RD && mem_WR) overlap_cnt <= overlap_cnt + 1;
            if (resp_valid) got_q.push_back({resp_rdata, resp_err, 8'(cyc_cnt + 1), 8'(rd_cnt), 8'(wr_cnt), wr_word});
        end
    end

    function automatic rsp_t mk(logic [31:0] rd, logic er, int lat, int nrd, int nwr, logic [31:0] w);
        return {rd, er, 8'(lat), 8'(nrd), 8'(nwr), w};
    endfunction

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input rsp_t exp);
        int guard;
        exp_q.push_back(exp);
        hold = exp.rdata;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge CLK); #1;
            guard++;
        end
        n_total++;
        if (!req_ready) $display("FAIL send_accept ready=%b required 1", req_ready);
        else n_pass++;
        @(posedge CLK); #1;
        acc_time = $time;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < 40) begin
            @(posedge CLK);
            guard++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        n_total++;
        if ({req_ready, resp_valid, resp_err, mem_RD, mem_WR} !== 5'b10000)
            $display("FAIL reset_ctrl got %b required 10000", {req_ready, resp_valid, resp_err, mem_RD, mem_WR});
        else n_pass++;
        n_total++;
        if ({resp_rdata, mem_DAddr, mem_DataIn} !== 96'h0)
            $display("FAIL reset_data got %h required 0", {resp_rdata, mem_DAddr, mem_DataIn});
        else n_pass++;
        @(negedge CLK);
        RST_n = 1'b1;
    endtask

    task automatic test_word;
        rsp_t g, e;
        send(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h1234_5678, mk(hold, 1'b0, 2, 0, 1, 32'h1234_5678));
        send(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, mk(32'h1234_5678, 1'b0, 2, 1, 0, 32'h0));
        wait_resp(2);
        repeat (2) begin
            n_total++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) $display("FAIL word_rw timeout, required %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL word_rw got %h required %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_byte_load;
        rsp_t g, e;
        send(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h12F4_5678, mk(hold, 1'b0, 2, 0, 1, 32'h12F4_5678));
        send(1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0, mk(32'hFFFF_FFF4, 1'b0, 2, 1, 0, 32'h0));
        send(1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0, mk(32'h0000_00F4, 1'b0, 2, 1, 0, 32'h0));
        send(1'b0, SZ_BYTE, 1'b0, 32'h08, 32'h0, mk(32'h0000_0012, 1'b0, 2, 1, 0, 32'h0));
        wait_resp(4);
        repeat (4) begin
            n_total++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) $display("FAIL byte_load timeout, required %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL byte_load got %h required %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sub_store;
        rsp_t g, e;
        send(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h1234_5678, mk(hold, 1'b0, 2, 0, 1, 32'h1234_5678));
        send(1'b1, SZ_BYTE, 1'b0, 32'h0A, 32'h0000_00AB, mk(hold, 1'b0, 3, 1, 1, 32'h1234_AB78));
        send(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, mk(32'h1234_AB78, 1'b0, 2, 1, 0, 32'h0));
        wait_resp(3);
        repeat (3) begin
            n_total++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) $display("FAIL sub_store timeout, required %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL sub_store got %h required %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_half;
        rsp_t g, e;
        send(1'b1, SZ_HALF, 1'b0, 32'h0C, 32'h0000_BEEF, mk(hold, 1'b0, 3, 1, 1, 32'hBEEF_0000));
        send(1'b0, SZ_HALF, 1'b0, 32'h0C, 32'h0, mk(32'hFFFF_BEEF, 1'b0, 2, 1, 0, 32'h0));
        send(1'b0, SZ_HALF, 1'b1, 32'h0C, 32'h0, mk(32'h0000_BEEF, 1'b0, 2, 1, 0, 32'h0));
        send(1'b0, SZ_HALF, 1'b0, 32'h0E, 32'h0, mk(32'h0000_0000, 1'b0, 2, 1, 0, 32'h0));
        wait_resp(4);
        repeat (4) begin
            n_total++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) $display("FAIL half timeout, required %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL half got %h required %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_misalign;
        rsp_t g, e;
        send(1'b1, SZ_WORD, 1'b0, 32'h04, 32'hCAFE_F00D, mk(hold, 1'b0, 2, 0, 1, 32'hCAFE_F00D));
`ifdef MISALIGN_TRAP_EN
        send(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, mk(hold, 1'b1, 1, 0, 0, 32'h0));
        send(1'b0, SZ_HALF, 1'b0, 32'h0D, 32'h0, mk(hold, 1'b1, 1, 0, 0, 32'h0));
        send(1'b0, SZ_RSVD, 1'b0, 32'h04, 32'h0, mk(hold, 1'b1, 1, 0, 0, 32'h0));
`else
        send(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, mk(32'hCAFE_F00D, 1'b0, 2, 1, 0, 32'h0));
        send(1'b0, SZ_HALF, 1'b0, 32'h0D, 32'h0, mk(32'hFFFF_BEEF, 1'b0, 2, 1, 0, 32'h0));
        send(1'b0, SZ_RSVD, 1'b0, 32'h04, 32'h0, mk(32'hCAFE_F00D, 1'b0, 2, 1, 0, 32'h0));
`endif
        wait_resp(4);
        repeat (4) begin
            n_total++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) $display("FAIL misalign timeout, required %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL misalign got %h required %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_range;
        rsp_t g, e;
        send(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, mk(hold, 1'b1, 1, 0, 0, 32'h0));
        send(1'b1, SZ_WORD, 1'b0, 32'h1C, 32'hA1B2_C3D4, mk(hold, 1'b0, 2, 0, 1, 32'hA1B2_C3D4));
        send(1'b0, SZ_BYTE, 1'b1, 32'h1F, 32'h0, mk(32'h0000_00D4, 1'b0, 2, 1, 0, 32'h0));
        send(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h5555_5555, mk(hold, 1'b1, 1, 0, 0, 32'h0));
        send(1'b0, SZ_BYTE, 1'b0, 32'hFFFF_FFFC, 32'h0, mk(hold, 1'b1, 1, 0, 0, 32'h0));
        wait_resp(5);
        repeat (5) begin
            n_total++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) $display("FAIL range timeout, required %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL range got %h required %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back;
        rsp_t g, e;
        time  t0;
        send(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h55AA_33CC, mk(hold, 1'b0, 2, 0, 1, 32'h55AA_33CC));
        t0 = acc_time;
        send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, mk(32'h55AA_33CC, 1'b0, 2, 1, 0, 32'h0));
        n_total++;
        if (acc_time - t0 != 30) $display("FAIL b2b_spacing got %0t required 30", acc_time - t0);
        else n_pass++;
        send(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000_1234, mk(hold, 1'b0, 3, 1, 1, 32'h55AA_1234));
        send(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, mk(32'h0000_1234, 1'b0, 2, 1, 0, 32'h0));
        wait_resp(4);
        repeat (4) begin
            n_total++;
            e = exp_q.pop_front();
            if (got_q.size() == 0) $display("FAIL b2b timeout, required %h", e);
            else begin
                g = got_q.pop_front();
                if (g !== e) $display("FAIL b2b got %h required %h", g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid;
        rsp_t g, e;
        send(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h1122_3344, mk(hold, 1'b0, 2, 0, 1, 32'h1122_3344));
        wait_resp(1);
        n_total++;
        e = exp_q.pop_front();
        if (got_q.size() == 0) $display("FAIL rst_mid_setup timeout, required %h", e);
        else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL rst_mid_setup got %h required %h", g, e);
            else n_pass++;
        end
        @(posedge CLK); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h0000_0099;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        n_total++;
        if (mem_RD !== 1'b1) $display("FAIL rst_mid_read mem_RD=%b required 1", mem_RD);
        else n_pass++;
        #2 RST_n = 1'b0;
        #1;
        n_total++;
        if ({mem_WR, mem_RD, req_ready, resp_valid} !== 4'b0010)
            $display("FAIL rst_mid_async got %b required 0010", {mem_WR, mem_RD, req_ready, resp_valid});
        else n_pass++;
        repeat (2) @(posedge CLK);
        #3 RST_n = 1'b1;
        hold = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        n_total++;
        if ({req_ready, resp_valid, resp_rdata} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL rst_mid_idle got %h required %h", {req_ready, resp_valid, resp_rdata}, {1'b1, 1'b0, 32'h0});
        else n_pass++;
        n_total++;
        if (mem[5] !== 32'h1122_3344) $display("FAIL rst_mid_mem got %h required 11223344", mem[5]);
        else n_pass++;
        n_total++;
        if (got_q.size() != 0) $display("FAIL rst_mid_noresp got %0d responses required 0", got_q.size());
        else n_pass++;
    endtask

    task automatic test_exclusive;
        n_total++;
        if (overlap_cnt != 0) $display("FAIL rd_wr_overlap got %0d cycles required 0", overlap_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_load();
        test_sub_store();
        test_half();
        test_misalign();
        test_range();
        test_back_to_back();
        test_reset_mid();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the data-memory interface for the multi-cycle MIPS core. Accepts one load/store request at a time from the MEM stage and drives the RD/WR/DAddr/DataIn/DataOut port of the big-endian, byte-addressed data memory. Handles byte, halfword and word sizes. Sub-word stores are done by read-modify-write. Load results are sign- or zero-extended, registered and returned with a one-cycle response pulse.

Parameters:
ADDR_W, 32, width of request and memory address
MEM_BYTES, 32, memory size in bytes; word address compared against MEM_BYTES-4

Ports:
CLK  in  1  clock; all state on posedge
RST_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  1 = zero-extend load (lbu/lhu)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified for sub-word
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data, held until next resp_valid
resp_err  out  1  valid with resp_valid; misalignment/range fault
mem_RD  out  1  memory read enable
mem_WR  out  1  memory write enable; memory samples on posedge
mem_DAddr  out  32  word-aligned address (low 2 bits always 0)
mem_DataIn  out  32  write word
mem_DataOut  in  32  combinational read word; only meaningful while mem_RD=1

Behaviour:
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_RD 0, mem_WR 0, mem_DAddr 0, mem_DataIn 0.
- Reset is asynchronous. Asserting it mid-operation drops mem_WR immediately, so no memory write occurs at the next edge.
- States: IDLE, READ, WRITE, RESP.
- IDLE on accept: latch all req fields.
  - load, or store with size≠word: go to READ.
  - word store: go to WRITE.
- READ: mem_RD=1 and mem_DAddr=addr&~3 for exactly one cycle. Capture mem_DataOut at the end of the cycle.
  - load: extract, extend into resp_rdata, go to RESP.
  - sub-word store: merge into captured word, go to WRITE.
- WRITE: mem_WR=1 for exactly one cycle with the merged or full word, then go to RESP.
- RESP: resp_valid=1 for one cycle, then go to IDLE. req_ready returns high the cycle after RESP.
- Latency from accept edge to resp_valid: word load 2 cycles, word store 2 cycles, sub-word store 3 cycles. Back-to-back requests therefore have one idle-ready cycle of spacing.
- mem_RD and mem_WR are never high together. Both are low in IDLE and RESP.
- Byte lanes are big-endian:
  - byte at addr[1:0]=0 occupies bits 31:24, =3 occupies bits 7:0.
  - half at addr[1]=0 occupies bits 31:16.
- Extension: signed replicates the lane MSB; req_unsigned zero-fills. Stores leave resp_rdata unchanged.
- Range: word address > MEM_BYTES-4 gives resp_err=1 with no memory access (READ/WRITE skipped, straight to RESP).

Optional Feature:
MISALIGN_TRAP_EN
- Defined: half with addr[0]=1, word with addr[1:0]≠0, or size 11 → no memory access, RESP with resp_err=1, resp_rdata unchanged.
- Undefined: offending low address bits are ignored (half uses addr[1], word uses lane 0), size 11 is treated as word, and resp_err is set only by the range check.

Decomposition:
- Shared package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, MEM_BYTES default.
- One natural sub-module, mem_lane_align: purely combinational. Performs load extract/extend and store merge given size, addr[1:0], unsigned flag, read word and write data. The FSM instantiates it once.

Test Plan:
- Store word 0x12345678 at 0x08, then load word at 0x08 → mem_WR high exactly 1 cycle with DataIn 0x12345678; load resp_rdata 0x12345678, resp_valid 2 cycles after accept.
- Load byte signed and unsigned from 0x09 after writing 0x12F45678 at 0x08 → 0xFFFFFFF4 and 0x000000F4 respectively.
- Store byte 0xAB at 0x0A over 0x12345678 → one READ cycle then one WRITE cycle with DataIn 0x1234AB78, resp_valid 3 cycles after accept; the following load of 0x08 returns 0x1234AB78.
- Store half 0xBEEF at 0x0C over 0x00000000 → word becomes 0xBEEF0000; signed half load at 0x0C returns 0xFFFFBEEF.
- With MISALIGN_TRAP_EN, load word at 0x06 → resp_err=1, mem_RD/mem_WR never asserted. Without the macro, the same request reads word 0x04, resp_err=0. Load at 0x20 with MEM_BYTES=32 → resp_err=1 in both builds.
- Drive RST_n low during the READ cycle of a sub-word store → mem_WR never asserts, memory unchanged, after release req_ready=1, resp_valid=0.
